// File: rtl/mesh_link_buf_if.sv
// Link bundle between two mesh tiles (A and B) and the buffer between them.
// The master modport is the tile side, the slave modport is the buffer.
interface mesh_link_buf_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH + 1);

    // Tile A side
    logic [WIDTH-1:0] send_data_A;
    logic             send_ready_A;
    logic             send_done_A;
    logic [WIDTH-1:0] recv_data_A;
    logic             recv_ready_A;
    logic             recv_valid_A;

    // Tile B side
    logic [WIDTH-1:0] send_data_B;
    logic             send_ready_B;
    logic             send_done_B;
    logic [WIDTH-1:0] recv_data_B;
    logic             recv_ready_B;
    logic             recv_valid_B;

    // Occupancy of each direction
    logic [CW-1:0]    count_AB;
    logic [CW-1:0]    count_BA;

    modport master (
        output send_data_A, send_ready_A, recv_ready_A,
        output send_data_B, send_ready_B, recv_ready_B,
        input  send_done_A, recv_data_A, recv_valid_A,
        input  send_done_B, recv_data_B, recv_valid_B,
        input  count_AB, count_BA
    );

    modport slave (
        input  send_data_A, send_ready_A, recv_ready_A,
        input  send_data_B, send_ready_B, recv_ready_B,
        output send_done_A, recv_data_A, recv_valid_A,
        output send_done_B, recv_data_B, recv_valid_B,
        output count_AB, count_BA
    );
endinterface

// File: rtl/mesh_link_buf.sv
// Bidirectional mesh link buffer: two independent FIFOs (A->B and B->A).
// Each FIFO accepts a push only when not full (judged on registered count,
// so a same-cycle pop never frees a slot early) and presents its head word
// from storage, giving one cycle of latency and no combinational paths
// between the sender and receiver sides.

module mesh_link_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [WIDTH-1:0] send_data,
    input  logic             send_ready,
    output logic             send_done,
    output logic [WIDTH-1:0] recv_data,
    input  logic             recv_ready,
    output logic             recv_valid,
    output logic [CW-1:0]    count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             push;
    logic             pop;

    // Push is gated by reset so send_done stays low while nRST is asserted.
    assign push       = send_ready & nRST & (count_q < CW'(DEPTH));
    assign pop        = recv_ready & (count_q != '0);
    assign send_done  = push;
    assign recv_valid = (count_q != '0);
    assign recv_data  = mem[rd_ptr];
    assign count      = count_q;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Pointer and occupancy bookkeeping.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Word storage.
    // NOTE: storage is deliberately not reset; count/pointers alone define
    // which entries are valid, and a reset-free array maps onto plain RAM.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= send_data;
    end
endmodule

module mesh_link_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic CLK,
    input  logic nRST,
    mesh_link_buf_if.slave link
);
    // A sends, B receives
    mesh_link_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ab (
        .CLK        (CLK),
        .nRST       (nRST),
        .send_data  (link.send_data_A),
        .send_ready (link.send_ready_A),
        .send_done  (link.send_done_A),
        .recv_data  (link.recv_data_B),
        .recv_ready (link.recv_ready_B),
        .recv_valid (link.recv_valid_B),
        .count      (link.count_AB)
    );

    // B sends, A receives
    mesh_link_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ba (
        .CLK        (CLK),
        .nRST       (nRST),
        .send_data  (link.send_data_B),
        .send_ready (link.send_ready_B),
        .send_done  (link.send_done_B),
        .recv_data  (link.recv_data_A),
        .recv_ready (link.recv_ready_A),
        .recv_valid (link.recv_valid_A),
        .count      (link.count_BA)
    );
endmodule

// File: doc/mesh_link_buf.md
MESH_LINK_BUF -- requirements
Module: mesh_link_buf

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data bits per word in each direction.
REQ-002 SHALL have parameter DEPTH, default 2, entries per direction FIFO; legal range 2..64, any integer, not restricted to powers of two.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port send_data_A  input  WIDTH  word offered by tile A.
REQ-006 SHALL have port send_ready_A  input  1  tile A requests to send send_data_A.
REQ-007 SHALL have port send_done_A  output  1  word from A accepted this cycle.
REQ-008 SHALL have port recv_data_A  output  WIDTH  head word of the B->A FIFO.
REQ-009 SHALL have port recv_ready_A  input  1  tile A can take a word this cycle.
REQ-010 SHALL have port recv_valid_A  output  1  recv_data_A holds a valid word.
REQ-011 SHALL have ports send_data_B, send_ready_B, send_done_B, recv_data_B, recv_ready_B, recv_valid_B, mirroring REQ-005..010 with A and B exchanged.
REQ-012 SHALL have ports count_AB, count_BA  output  $clog2(DEPTH+1)  current occupancy of each direction FIFO.

Function
REQ-013 SHALL implement two independent FIFOs, AB (A sends, B receives) and BA; all rules below are stated for AB and apply identically to BA.
REQ-014 Push: send_done_A = send_ready_A & (count_AB < DEPTH); on that edge send_data_A is written at wr_ptr and wr_ptr advances.
REQ-015 send_done_A SHALL depend only on send_ready_A and registered state, never on recv_ready_B; no combinational path from recv_ready_B to send_done_A.
REQ-016 Pop: recv_valid_B = (count_AB != 0); recv_data_B = entry at rd_ptr; a word is consumed on the edge where recv_valid_B & recv_ready_B, and rd_ptr advances.
REQ-017 recv_data_B and recv_valid_B SHALL be driven from registers and FIFO storage only; no combinational path from any A-side input.
REQ-018 Latency: a word pushed at edge N SHALL appear on recv_data_B with recv_valid_B=1 in the cycle following edge N (1 cycle); there is no same-cycle flow-through.
REQ-019 Ordering SHALL be strict FIFO per direction; no word is lost or duplicated.
REQ-020 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-021 Full: when count_AB == DEPTH, send_done_A=0 even if a pop occurs in the same cycle; the freed slot is usable from the next cycle.
REQ-022 Empty: when count_AB == 0, recv_valid_B=0, recv_ready_B is ignored, and pointers and count are unchanged by it.
REQ-023 Simultaneous push and pop with 0 < count_AB < DEPTH SHALL leave count_AB unchanged and advance both pointers.
REQ-024 count_AB SHALL equal previous count + push - pop every cycle and never exceed DEPTH or go below 0.
REQ-025 The two directions SHALL not interact; a full AB SHALL not stall BA.
REQ-026 recv_data_B when recv_valid_B=0 is don't-care; the bench SHALL not check it.

Reset
REQ-027 nRST low SHALL asynchronously clear both FIFOs: pointers=0, count_AB=count_BA=0, recv_valid_A=recv_valid_B=0, send_done_A/B = 0 while nRST is low.
REQ-028 Reset mid-transfer SHALL discard all buffered words; storage contents need not be cleared.
REQ-029 After nRST rises, the first push SHALL be accepted on the first rising edge with send_ready asserted.

Verification
REQ-030 Single word: WIDTH=32, DEPTH=2; A pushes 0xDEADBEEF at edge 1 with recv_ready_B=1 -> send_done_A=1 in cycle 0, recv_valid_B=1 with recv_data_B=0xDEADBEEF in cycle 1, count_AB returns to 0 after edge 2.
REQ-031 Fill/backpressure: recv_ready_B=0; A pushes 1,2,3 -> 1,2 accepted, count_AB=2; send_done_A=0 for 3; raise recv_ready_B -> 1 popped and 3 still refused that cycle, then 3 accepted next cycle; B receives 1,2,3 in order.
REQ-032 Wrap: DEPTH=3, stream 10 words 0..9 with recv_ready_B toggling every cycle -> all 10 received in order, count_AB never exceeds 3.
REQ-033 Bidirectional independence: BA full (B pushes 0xA,0xB, recv_ready_A=0) while A streams 0x100..0x104 with recv_ready_B=1 -> AB delivers all 5 at 1 word/cycle, BA holds count_BA=2.
REQ-034 Reset mid-operation: count_AB=2, assert nRST asynchronously between edges -> recv_valid_B=0 and count_AB=0 immediately; after release, push 0x55 -> only 0x55 is delivered.
REQ-035 Random: 10k cycles of random send_ready/recv_ready on both sides, DEPTH in {2,5} -> scoreboard matches, count equals the model every cycle.
